sync_fifo_ctrl: RTL and testbench

Parametrised single-clock FIFO, successor to the basic 16x8 buffer. Adds:
- a correct simultaneous read/write path;
- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full/almost-empty thresholds;
- an occupancy output;
- one-cycle overflow/underflow error pulses.

It sits between producer and consumer datapaths in the same clock domain.

---
 rtl/sync_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with selectable registered / fall-through read,
// programmable almost-full/empty thresholds, occupancy and error pulses.
module sync_fifo_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;

    // Acceptance, pointer/count update and next-cycle flags/data
    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        wr_acc   = wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_LEVEL));
        ae_d    = (count_d <= CW'(AE_LEVEL));
        ovf_d   = wr_en & ~wr_acc;
        udf_d   = rd_en & ~rd_acc;

        if (FWFT != 0) begin
            // Next head word; bypass when the word being written becomes the head
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                data_d = data_in;
            end else begin
                data_d = mem[rd_ptr_d];
            end
            rd_valid_d = ~empty_d;
        end else begin
            if (rd_acc) begin
                data_d = mem[rd_ptr_q];
            end
            rd_valid_d = rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign data_out     = data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: registered-read, fall-through and
// non-power-of-two depth instances.
module tb_sync_fifo_ctrl;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0: DEPTH 16, registered read
    logic       rst0, wr0, rd0;
    logic [7:0] din0, dout0;
    logic       rv0, full0, empty0, af0, ae0, ovf0, udf0;
    logic [4:0] cnt0;

    // u1: DEPTH 16, fall-through
    logic       rst1, wr1, rd1;
    logic [7:0] din1, dout1;
    logic       rv1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] cnt1;

    // u2: DEPTH 5, AF 4, AE 1
    logic       rst2, wr2, rd2;
    logic [7:0] din2, dout2;
    logic       rv2, full2, empty2, af2, ae2, ovf2, udf2;
    logic [2:0] cnt2;

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u0 (
        .clk(clk), .rst(rst0), .wr_en(wr0), .data_in(din0), .rd_en(rd0),
        .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0));

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u1 (
        .clk(clk), .rst(rst1), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
        .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1));

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u2 (
        .clk(clk), .rst(rst2), .wr_en(wr2), .data_in(din2), .rd_en(rd2),
        .data_out(dout2), .rd_valid(rv2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .count(cnt2),
        .overflow(ovf2), .underflow(udf2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        wr0 = 1'b1; rd0 = 1'b1; din0 = 8'hEE;
        wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;
        wr2 = 1'b0; rd2 = 1'b0; din2 = 8'h00;
        step();
        checks++;
        if ({cnt0, empty0, ae0, full0, af0, rv0, ovf0, udf0} !== {5'd0, 7'b1100000}) begin
            errors++;
            $display("FAIL reset_flags got cnt=%0d e=%b ae=%b f=%b af=%b rv=%b ov=%b uf=%b exp cnt=0 e=1 ae=1 others 0",
                     cnt0, empty0, ae0, full0, af0, rv0, ovf0, udf0);
        end
        checks++;
        if (dout0 !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h exp 00", dout0);
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        wr0 = 1'b0; rd0 = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            wr0 = 1'b1; din0 = 8'(i);
            step();
            checks++;
            if (cnt0 !== 5'(i) || af0 !== (i >= 14) || full0 !== (i == 16) || empty0 !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d got cnt=%0d af=%b full=%b empty=%b", i, cnt0, af0, full0, empty0);
            end
        end
        din0 = 8'hAA;
        step();
        checks++;
        if (ovf0 !== 1'b1 || cnt0 !== 5'd16) begin
            errors++; $display("FAIL overflow_pulse got ov=%b cnt=%0d exp 1 16", ovf0, cnt0);
        end
        wr0 = 1'b0;
        step();
        checks++;
        if (ovf0 !== 1'b0 || cnt0 !== 5'd16) begin
            errors++; $display("FAIL overflow_clear got ov=%b cnt=%0d exp 0 16", ovf0, cnt0);
        end
        for (int i = 1; i <= 16; i++) begin
            rd0 = 1'b1;
            step();
            checks++;
            if (rv0 !== 1'b1 || dout0 !== 8'(i) || cnt0 !== 5'(16 - i)) begin
                errors++;
                $display("FAIL drain_%0d got rv=%b data=%h cnt=%0d exp 1 %h %0d", i, rv0, dout0, cnt0, 8'(i), 16 - i);
            end
        end
        rd0 = 1'b0;
        step();
        checks++;
        if (rv0 !== 1'b0 || empty0 !== 1'b1 || dout0 !== 8'h10 || ae0 !== 1'b1) begin
            errors++; $display("FAIL drain_idle got rv=%b empty=%b data=%h ae=%b", rv0, empty0, dout0, ae0);
        end
    endtask

    task automatic test_underflow();
        rd0 = 1'b1;
        step();
        checks++;
        if (udf0 !== 1'b1 || cnt0 !== 5'd0 || rv0 !== 1'b0) begin
            errors++; $display("FAIL underflow got uf=%b cnt=%0d rv=%b exp 1 0 0", udf0, cnt0, rv0);
        end
        wr0 = 1'b1; din0 = 8'h55;
        step();
        checks++;
        if (udf0 !== 1'b1 || cnt0 !== 5'd1 || rv0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL no_bypass got uf=%b cnt=%0d rv=%b ov=%b exp 1 1 0 0", udf0, cnt0, rv0, ovf0);
        end
        wr0 = 1'b0;
        step();
        checks++;
        if (udf0 !== 1'b0 || rv0 !== 1'b1 || dout0 !== 8'h55 || cnt0 !== 5'd0) begin
            errors++; $display("FAIL read_55 got uf=%b rv=%b data=%h cnt=%0d", udf0, rv0, dout0, cnt0);
        end
        rd0 = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        for (int i = 1; i <= 16; i++) begin
            wr0 = 1'b1; din0 = 8'(i);
            step();
        end
        checks++;
        if (full0 !== 1'b1) begin
            errors++; $display("FAIL b2b_full got %b exp 1", full0);
        end
        rd0 = 1'b1; din0 = 8'h77;
        for (int k = 0; k < 20; k++) begin
            exp_d = (k < 16) ? 8'(k + 1) : 8'h77;
            step();
            checks++;
            if (ovf0 !== 1'b0 || cnt0 !== 5'd16 || rv0 !== 1'b1 || dout0 !== exp_d) begin
                errors++;
                $display("FAIL b2b_%0d got ov=%b cnt=%0d rv=%b data=%h exp 0 16 1 %h", k, ovf0, cnt0, rv0, dout0, exp_d);
            end
        end
        wr0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (dout0 !== 8'h77 || cnt0 !== 5'(15 - k)) begin
                errors++; $display("FAIL b2b_drain_%0d got data=%h cnt=%0d exp 77 %0d", k, dout0, cnt0, 15 - k);
            end
        end
        rd0 = 1'b0;
        step();
    endtask

    task automatic test_fwft();
        wr1 = 1'b1; din1 = 8'h3C;
        step();
        checks++;
        if (empty1 !== 1'b0 || rv1 !== 1'b1 || dout1 !== 8'h3C) begin
            errors++; $display("FAIL fwft_first got empty=%b rv=%b data=%h exp 0 1 3c", empty1, rv1, dout1);
        end
        wr1 = 1'b0; rd1 = 1'b1;
        step();
        checks++;
        if (empty1 !== 1'b1 || rv1 !== 1'b0) begin
            errors++; $display("FAIL fwft_pop got empty=%b rv=%b exp 1 0", empty1, rv1);
        end
        rd1 = 1'b0; wr1 = 1'b1; din1 = 8'hA1;
        step();
        din1 = 8'hA2;
        step();
        checks++;
        if (dout1 !== 8'hA1 || cnt1 !== 5'd2) begin
            errors++; $display("FAIL fwft_head got data=%h cnt=%0d exp a1 2", dout1, cnt1);
        end
        rd1 = 1'b1; din1 = 8'hA3;
        step();
        checks++;
        if (dout1 !== 8'hA2 || cnt1 !== 5'd2 || rv1 !== 1'b1) begin
            errors++; $display("FAIL fwft_rw got data=%h cnt=%0d rv=%b exp a2 2 1", dout1, cnt1, rv1);
        end
        wr1 = 1'b0;
        step();
        checks++;
        if (dout1 !== 8'hA3 || cnt1 !== 5'd1) begin
            errors++; $display("FAIL fwft_last got data=%h cnt=%0d exp a3 1", dout1, cnt1);
        end
        step();
        checks++;
        if (empty1 !== 1'b1 || rv1 !== 1'b0 || cnt1 !== 5'd0) begin
            errors++; $display("FAIL fwft_empty got empty=%b rv=%b cnt=%0d exp 1 0 0", empty1, rv1, cnt1);
        end
        rd1 = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) begin
            wr0 = 1'b1; din0 = 8'(8'h90 + i);
            step();
        end
        checks++;
        if (cnt0 !== 5'd9) begin
            errors++; $display("FAIL prereset_count got %0d exp 9", cnt0);
        end
        rst0 = 1'b1; din0 = 8'hEE; rd0 = 1'b1;
        step();
        checks++;
        if (cnt0 !== 5'd0 || empty0 !== 1'b1 || dout0 !== 8'h00 || rv0 !== 1'b0 || full0 !== 1'b0) begin
            errors++; $display("FAIL mid_reset got cnt=%0d empty=%b data=%h rv=%b", cnt0, empty0, dout0, rv0);
        end
        rst0 = 1'b0; rd0 = 1'b0; din0 = 8'h5A;
        step();
        checks++;
        if (cnt0 !== 5'd1) begin
            errors++; $display("FAIL post_reset_write got cnt=%0d exp 1", cnt0);
        end
        wr0 = 1'b0; rd0 = 1'b1;
        step();
        checks++;
        if (dout0 !== 8'h5A || rv0 !== 1'b1 || empty0 !== 1'b1) begin
            errors++; $display("FAIL post_reset_read got data=%h rv=%b empty=%b exp 5a 1 1", dout0, rv0, empty0);
        end
        rd0 = 1'b0;
    endtask

    task automatic test_depth5();
        // Offset pointers to 3 so the main pass wraps 4 -> 0
        for (int i = 0; i < 3; i++) begin
            wr2 = 1'b1; din2 = 8'(8'h50 + i);
            step();
        end
        wr2 = 1'b0; rd2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        rd2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr2 = 1'b1; din2 = 8'(8'h60 + i);
            step();
            checks++;
            if (cnt2 !== 3'(i) || af2 !== (i >= 4) || full2 !== (i == 5) || ae2 !== (i <= 1)) begin
                errors++;
                $display("FAIL d5_fill_%0d got cnt=%0d af=%b full=%b ae=%b", i, cnt2, af2, full2, ae2);
            end
        end
        wr2 = 1'b0; rd2 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (dout2 !== 8'(8'h60 + i) || cnt2 !== 3'(5 - i) || ae2 !== ((5 - i) <= 1) || af2 !== ((5 - i) >= 4)) begin
                errors++;
                $display("FAIL d5_read_%0d got data=%h cnt=%0d ae=%b af=%b exp %h %0d",
                         i, dout2, cnt2, ae2, af2, 8'(8'h60 + i), 5 - i);
            end
        end
        rd2 = 1'b0;
        step();
        checks++;
        if (empty2 !== 1'b1 || rv2 !== 1'b0 || ovf2 !== 1'b0 || udf2 !== 1'b0) begin
            errors++; $display("FAIL d5_end got empty=%b rv=%b ov=%b uf=%b", empty2, rv2, ovf2, udf2);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_mid_reset();
        test_depth5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
